mux_nx1_rr: RTL and testbench
=============================

Name: mux_nx1_rr

Overview:
- Parametrised, registered N:1 multiplexer with per-channel valid/ready handshakes and a registered output stage.
- Successor to the fixed-width, fixed-depth, purely combinational 2:1-tree muxes; generalised to N_CH channels of WIDTH bits.
- Three selection modes: direct select, fixed priority, round-robin.
- Sits between multiple producer streams and a single consumer; arbitrates and forwards one word per cycle.

Parameters:
- N_CH, 9, number of input channels (2..16).
- WIDTH, 8, data width per channel.
- SEL_W, 4, width of sel and out_chan; must satisfy 2**SEL_W >= N_CH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mode  input  2  0 = direct (sel), 1 = fixed priority (lowest index wins), 2 = round-robin, 3 = reserved (no grant).
- sel  input  SEL_W  channel index used in mode 0.
- in_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready (combinational, one-hot or zero).
- out_data  output  WIDTH  registered data.
- out_chan  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_chan=0, rr_ptr=0. in_ready is 0 whenever rst=1.
- load_en = !out_valid || out_ready. No arbitration takes place when load_en=0, and in_ready is all zero.
- Grant selection, evaluated combinationally each cycle with load_en=1:
  - mode 0: grant = sel if sel < N_CH and in_valid[sel]; otherwise no grant. sel >= N_CH is never granted.
  - mode 1: grant = lowest k with in_valid[k]=1.
  - mode 2: grant = first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ..., N_CH-1, 0, ..., rr_ptr-1.
  - mode 3: no grant.
- in_ready[g]=1 only for the granted channel g. A transfer on channel g occurs when in_valid[g] && in_ready[g].
- On a transfer: at the next edge out_data <= channel g data, out_chan <= g, out_valid <= 1. In mode 2 only, rr_ptr <= (g==N_CH-1) ? 0 : g+1.
- rr_ptr is unchanged in modes 0, 1 and 3, and on any cycle without a transfer.
- If load_en=1 and there is no grant: out_valid <= 0 at the next edge. out_data and out_chan hold their previous values.
- If out_valid=1 and out_ready=0: out_data, out_chan and out_valid hold (backpressure).
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle while out_ready=1. Simultaneous output drain and new load in the same cycle is allowed and required.
- mode or sel changes take effect on the same cycle's combinational grant. A mode change does not reset rr_ptr.
- rst asserted mid-transfer discards the output word. The input handshake in that cycle is not completed, because in_ready=0.
- The in_valid of non-granted channels has no effect. Producers must hold their data while valid and not ready.

Test Plan:
- Reset/idle: hold rst=1 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_chan=0. Release rst with in_valid=0 -> out_valid stays 0.
- Direct mode: mode=0, sel=5, in_valid=9'h1FF, channel k data = 8'h10+k, out_ready=1 -> in_ready=9'h020; one cycle later out_data=8'h15, out_chan=5, out_valid=1. With sel=9 -> in_ready=0, and out_valid falls to 0 the following cycle.
- Fixed priority: mode=1, in_valid=9'b1_0010_1000 -> successive grants 3, 3, 3 while valid is held. Drop in_valid[3] -> grant 5, then 8.
- Round-robin fairness: mode=2, all in_valid=1, out_ready=1 for 20 cycles -> out_chan sequence 0,1,...,8,0,1,...; each channel is granted exactly twice in the first 18 outputs. With in_valid=9'b1_0000_0001 the grants alternate 0, 8, 0, 8.
- Backpressure: out_valid=1 with out_data=8'h13, then out_ready=0 for 3 cycles -> out_data, out_chan and out_valid are stable and in_ready=0. Raise out_ready -> the next word loads in the same cycle and there are no bubbles.
- Reset mid-stream: mode=2, rr_ptr=4, out_valid=1, then rst pulsed for 1 cycle -> out_valid=0 and rr_ptr=0; the first grant after reset is channel 0 with all channels valid.

Source files
------------

// File: rtl/mux_nx1_rr_if.sv
// Handshake/bus bundle for mux_nx1_rr.
//   mode, sel          : selection controls (consumer side drives)
//   in_data, in_valid  : N_CH producer streams, channel k at [k*WIDTH +: WIDTH]
//   in_ready           : per-channel ready, one-hot or zero
//   out_data, out_chan : registered output word and its source channel
//   out_valid          : registered output valid
//   out_ready          : consumer ready
// master = environment side, slave = the mux.
interface mux_nx1_rr_if #(
   parameter int unsigned N_CH  = 9,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SEL_W = 4
);
   logic [1:0]            mode;
   logic [SEL_W-1:0]      sel;
   logic [N_CH*WIDTH-1:0] in_data;
   logic [N_CH-1:0]       in_valid;
   logic [N_CH-1:0]       in_ready;
   logic [WIDTH-1:0]      out_data;
   logic [SEL_W-1:0]      out_chan;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/mux_nx1_rr.sv
// Registered N:1 stream multiplexer with direct, fixed-priority and round-robin selection.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mux_nx1_rr_if slave modport (mode/sel, N_CH input streams, one output stream)
// One word per cycle is forwarded; the output register drains and reloads in the same cycle.
module mux_nx1_rr #(
   parameter int unsigned N_CH  = 9,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SEL_W = 4
) (
   input logic         clk,
   input logic         rst,
   mux_nx1_rr_if.slave bus
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_chan_q, out_chan_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             load_en;
   logic             gnt_valid;
   logic [SEL_W-1:0] gnt_idx;
   logic [WIDTH-1:0] gnt_data;

   // Round-robin helpers: lowest valid channel at/after the pointer, and lowest overall.
   logic             hi_hit, lo_hit;
   logic [SEL_W-1:0] hi_idx, lo_idx;

   // Output register can accept a new word when empty or being drained this cycle.
   assign load_en = !out_valid_q || bus.out_ready;

   always_comb begin
      hi_hit = 1'b0;
      hi_idx = '0;
      lo_hit = 1'b0;
      lo_idx = '0;
      // Descending scan so the lowest matching index is the last one written.
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
         if (bus.in_valid[k]) begin
            lo_hit = 1'b1;
            lo_idx = SEL_W'(k);
            if (SEL_W'(k) >= rr_ptr_q) begin
               hi_hit = 1'b1;
               hi_idx = SEL_W'(k);
            end
         end
      end
   end

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      if (!rst && load_en) begin
         case (bus.mode)
            2'd0: begin
               // Compare against each real channel so sel >= N_CH never matches.
               for (int unsigned k = 0; k < N_CH; k++) begin
                  if (bus.sel == SEL_W'(k) && bus.in_valid[k]) begin
                     gnt_valid = 1'b1;
                     gnt_idx   = SEL_W'(k);
                  end
               end
            end
            2'd1: begin
               gnt_valid = lo_hit;
               gnt_idx   = lo_idx;
            end
            2'd2: begin
               // Wrap-around search: anything at/after the pointer first, else the lowest.
               gnt_valid = hi_hit || lo_hit;
               gnt_idx   = hi_hit ? hi_idx : lo_idx;
            end
            default: begin
               gnt_valid = 1'b0;
               gnt_idx   = '0;
            end
         endcase
      end
   end

   always_comb begin
      gnt_data     = '0;
      bus.in_ready = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (gnt_idx == SEL_W'(k)) begin
            gnt_data = bus.in_data[k*WIDTH +: WIDTH];
         end
         bus.in_ready[k] = gnt_valid && (gnt_idx == SEL_W'(k));
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      rr_ptr_d    = rr_ptr_q;
      if (load_en) begin
         out_valid_d = gnt_valid;
         if (gnt_valid) begin
            out_data_d = gnt_data;
            out_chan_d = gnt_idx;
            if (bus.mode == 2'd2) begin
               rr_ptr_d = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Self-checking bench for mux_nx1_rr: directed scenarios followed by random traffic,
// scored against a behavioural model and an expected-output queue.
module tb_mux_nx1_rr;
   localparam int unsigned N  = 9;
   localparam int unsigned W  = 8;
   localparam int unsigned SW = 4;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [SW-1:0] chan;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mux_nx1_rr_if #(.N_CH(N), .WIDTH(W), .SEL_W(SW)) bus ();

   mux_nx1_rr #(.N_CH(N), .WIDTH(W), .SEL_W(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];
   logic m_valid = 1'b0;
   int   m_ptr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Grant straight from the selection rules.
   function automatic int ref_grant(input int md, input int sl, input logic [N-1:0] v,
                                    input int ptr);
      int c;
      if (md == 0) return (sl < int'(N) && v[sl]) ? sl : -1;
      if (md == 1) begin
         for (int i = 0; i < int'(N); i++) if (v[i]) return i;
         return -1;
      end
      if (md == 2) begin
         for (int i = 0; i < int'(N); i++) begin
            c = (ptr + i) % int'(N);
            if (v[c]) return c;
         end
         return -1;
      end
      return -1;
   endfunction

   // Evaluated just before each active edge, with inputs stable.
   task automatic model_step();
      int            g;
      bit            load;
      logic [N-1:0]  er;
      exp_t          e;
      if (rst) begin
         check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
         m_valid = 1'b0;
         m_ptr   = 0;
         sb.delete();
      end else begin
         check("out_valid", 32'(bus.out_valid), 32'(m_valid));
         load = !m_valid || bus.out_ready;
         g    = load ? ref_grant(int'(bus.mode), int'(bus.sel), bus.in_valid, m_ptr) : -1;
         er   = '0;
         if (g >= 0) er[g] = 1'b1;
         check("in_ready", 32'(bus.in_ready), 32'(er));
         if (load) begin
            if (g >= 0) begin
               e.data = bus.in_data[g*W +: W];
               e.chan = SW'(g);
               sb.push_back(e);
               m_valid = 1'b1;
               if (bus.mode == 2'd2) m_ptr = (g + 1) % int'(N);
            end else begin
               m_valid = 1'b0;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ramp_data();
      for (int k = 0; k < int'(N); k++) bus.in_data[k*W +: W] = W'(8'h10 + k);
   endtask

   // Monitor: pop and compare whenever the consumer takes a word.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_underflow: got word %h/%0d expected none at %0t",
                        bus.out_data, bus.out_chan, $time);
            end else begin
               e = sb.pop_front();
               check("out_data", 32'(bus.out_data), 32'(e.data));
               check("out_chan", 32'(bus.out_chan), 32'(e.chan));
            end
         end
      end
   end

   initial begin
      bus.mode      = 2'd0;
      bus.sel       = '0;
      bus.in_valid  = '1;
      bus.out_ready = 1'b1;
      set_ramp_data();

      // Reset with all channels valid.
      rst = 1'b1;
      tick();
      tick();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_chan", 32'(bus.out_chan), 32'd0);
      rst = 1'b0;
      bus.in_valid = '0;
      tick();
      tick();

      // Direct select.
      bus.mode = 2'd0;
      bus.sel = 4'd5;
      bus.in_valid = 9'h1FF;
      tick();
      check("direct_data", 32'(bus.out_data), 32'h15);
      check("direct_chan", 32'(bus.out_chan), 32'd5);
      check("direct_valid", 32'(bus.out_valid), 32'd1);
      bus.sel = 4'd9;
      tick();
      tick();

      // Fixed priority.
      bus.mode = 2'd1;
      bus.in_valid = 9'b1_0010_1000;
      repeat (3) tick();
      bus.in_valid = 9'b1_0010_0000;
      tick();
      bus.in_valid = 9'b1_0000_0000;
      tick();

      // Round-robin fairness, then the two-channel alternation.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.mode = 2'd2;
      bus.in_valid = '1;
      repeat (20) tick();
      bus.in_valid = 9'b1_0000_0001;
      repeat (4) tick();

      // Backpressure with 8'h13 held in the output register.
      bus.mode = 2'd1;
      bus.in_valid = 9'b0_0000_1000;
      tick();
      check("bp_data", 32'(bus.out_data), 32'h13);
      bus.out_ready = 1'b0;
      bus.in_valid = '1;
      repeat (3) tick();
      bus.out_ready = 1'b1;
      repeat (3) tick();

      // Reset mid-stream with the pointer at 4.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.mode = 2'd2;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      rst = 1'b0;
      tick();
      check("midrst_first_chan", 32'(bus.out_chan), 32'd0);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         bus.mode      = 2'($urandom_range(0, 3));
         bus.sel       = SW'($urandom_range(0, 15));
         bus.in_valid  = N'($urandom);
         bus.in_data   = {$urandom, $urandom, $urandom};
         bus.out_ready = ($urandom_range(0, 9) < 7);
         rst           = ($urandom_range(0, 49) == 0);
         tick();
      end

      // Drain.
      rst = 1'b0;
      bus.mode = 2'd3;
      bus.out_ready = 1'b1;
      repeat (2) tick();
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
